// File: rtl/twiddle_pkg.sv
// Shared types and the quarter-wave cosine builder for the FFT twiddle generator.
package twiddle_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DRAIN
  } state_t;

  localparam logic [1:0] QUAD_0 = 2'd0;
  localparam logic [1:0] QUAD_1 = 2'd1;
  localparam logic [1:0] QUAD_2 = 2'd2;
  localparam logic [1:0] QUAD_3 = 2'd3;

  localparam real PI = 3.14159265358979323846;

  // The endpoints are pinned so floating-point residue cannot push cos(pi/2) below zero.
  function automatic int cos_q(input int i, input int n_log2, input int frac);
    real ang;
    int quarter;
    quarter = 1 << (n_log2 - 2);
    if (i == 0) return 1 << frac;
    if (i >= quarter) return 0;
    ang = 2.0 * PI * real'(i) / real'(1 << n_log2);
    return int'($floor(real'(1 << frac) * $cos(ang)));
  endfunction

endpackage

// File: rtl/twiddle_qrom.sv
// Quarter-wave cosine ROM, N/4+1 entries, with two registered read ports.
module twiddle_qrom
  import twiddle_pkg::*;
#(
  parameter int N_LOG2 = 6,
  parameter int WIDTH  = 12,
  parameter int FRAC   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [N_LOG2-2:0] addr_a,
  input  logic [N_LOG2-2:0] addr_b,
  output logic [WIDTH-1:0]  data_a,
  output logic [WIDTH-1:0]  data_b
);

  localparam int Q = 1 << (N_LOG2 - 2);

  logic [WIDTH-1:0] rom [0:Q];

  for (genvar g = 0; g <= Q; g++) begin : g_rom
    assign rom[g] = WIDTH'(cos_q(g, N_LOG2, FRAC));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_a <= '0;
      data_b <= '0;
    end else if (en) begin
      data_a <= rom[addr_a];
      data_b <= rom[addr_b];
    end
  end

endmodule

// File: rtl/twiddle_gen.sv
// Pipelined FFT twiddle generator: random-access lookup plus per-stage auto-sweep.
// Optional conjugate output (IFFT) is enabled by defining TWIDDLE_CONJ_EN.
module twiddle_gen
  import twiddle_pkg::*;
#(
  parameter int N_LOG2 = 6,
  parameter int WIDTH  = 12,
  parameter int FRAC   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [N_LOG2-1:0]         req_k,
  input  logic                      sweep_start,
  input  logic [$clog2(N_LOG2)-1:0] sweep_stage,
  output logic                      sweep_busy,
  output logic                      tw_valid,
  input  logic                      tw_ready,
`ifdef TWIDDLE_CONJ_EN
  input  logic                      conj,
`endif
  output logic [N_LOG2-1:0]         tw_k,
  output logic [WIDTH-1:0]          tw_cos,
  output logic [WIDTH-1:0]          tw_sin,
  output logic                      tw_last
);

  localparam int N  = 1 << N_LOG2;
  localparam int Q  = N / 4;
  localparam int AW = N_LOG2 - 1;
  localparam int SW = $clog2(N_LOG2);

  state_t state, state_next;

  logic              conj_req;
  logic              stall, advance;
  logic              req_fire, start_fire, last_accept;
  logic              issue_valid, issue_last, issue_conj;
  logic [N_LOG2-1:0] issue_k;
  logic [N_LOG2-1:0] sweep_k, sweep_stride, sweep_left;
  logic              sweep_conj;
  logic [SW-1:0]     stage_eff;

  logic              s1_valid, s1_exact, s1_last, s1_conj;
  logic [1:0]        s1_q;
  logic [N_LOG2-1:0] s1_k;
  logic [AW-1:0]     rom_addr_a, rom_addr_b;
  logic [WIDTH-1:0]  rom_a, rom_b;
  logic [WIDTH-1:0]  cos_mag, sin_mag;
  logic              cos_neg, sin_neg;

`ifdef TWIDDLE_CONJ_EN
  assign conj_req = conj;
`else
  assign conj_req = 1'b0;
`endif

  assign stall       = tw_valid && !tw_ready;
  assign advance     = !stall;
  assign req_ready   = !rst && advance && (state == IDLE);
  assign req_fire    = req_valid && req_ready;
  assign start_fire  = sweep_start && (state == IDLE) && !req_fire;
  assign last_accept = tw_valid && tw_ready && tw_last;
  assign sweep_busy  = (state != IDLE);

  always_comb begin
    stage_eff = sweep_stage;
    if (int'(sweep_stage) > N_LOG2 - 1) stage_eff = SW'(N_LOG2 - 1);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    issue_valid = 1'b0;
    issue_k     = req_k;
    issue_last  = 1'b0;
    issue_conj  = conj_req;
    case (state)
      IDLE: begin
        issue_valid = req_fire;
        if (start_fire) state_next = SWEEP;
      end
      SWEEP: begin
        issue_k     = sweep_k;
        issue_conj  = sweep_conj;
        issue_last  = (sweep_left == N_LOG2'(1));
        issue_valid = advance;
        if (advance && issue_last) state_next = DRAIN;
      end
      DRAIN: begin
        if (last_accept) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sweep_k      <= '0;
      sweep_stride <= '0;
      sweep_left   <= '0;
      sweep_conj   <= 1'b0;
    end else if (start_fire) begin
      sweep_k      <= '0;
      sweep_stride <= N_LOG2'(1) << stage_eff;
      sweep_left   <= N_LOG2'(N / 2) >> stage_eff;
      sweep_conj   <= conj_req;
    end else if (state == SWEEP && advance) begin
      sweep_k      <= sweep_k + sweep_stride;
      sweep_left   <= sweep_left - N_LOG2'(1);
    end
  end

  // Port A reads C[r], port B reads C[N/4-r]; quadrant logic picks between them.
  assign rom_addr_a = {1'b0, issue_k[N_LOG2-3:0]};
  assign rom_addr_b = AW'(Q) - rom_addr_a;

  twiddle_qrom #(
    .N_LOG2(N_LOG2),
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_qrom (
    .clk   (clk),
    .rst   (rst),
    .en    (advance),
    .addr_a(rom_addr_a),
    .addr_b(rom_addr_b),
    .data_a(rom_a),
    .data_b(rom_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_k     <= '0;
      s1_q     <= QUAD_0;
      s1_exact <= 1'b0;
      s1_last  <= 1'b0;
      s1_conj  <= 1'b0;
    end else if (advance) begin
      s1_valid <= issue_valid;
      s1_k     <= issue_k;
      s1_q     <= issue_k[N_LOG2-1 -: 2];
      s1_exact <= (issue_k[N_LOG2-3:0] == '0);
      s1_last  <= issue_valid && issue_last;
      s1_conj  <= issue_conj;
    end
  end

  // Exact table values (1.0 and 0) need a true negate; fractional ones use ~v to keep floor().
  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                  input logic neg, input logic exact);
    if (!neg) return v;
    return exact ? -v : ~v;
  endfunction

  always_comb begin
    cos_mag = ((s1_q == QUAD_0) || (s1_q == QUAD_2)) ? rom_a : rom_b;
    sin_mag = ((s1_q == QUAD_0) || (s1_q == QUAD_2)) ? rom_b : rom_a;
    cos_neg = (s1_q == QUAD_1) || (s1_q == QUAD_2);
    sin_neg = ((s1_q == QUAD_0) || (s1_q == QUAD_1)) ^ s1_conj;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tw_valid <= 1'b0;
      tw_k     <= '0;
      tw_cos   <= '0;
      tw_sin   <= '0;
      tw_last  <= 1'b0;
    end else if (advance) begin
      tw_valid <= s1_valid;
      tw_k     <= s1_k;
      tw_cos   <= apply_sign(cos_mag, cos_neg, s1_exact);
      tw_sin   <= apply_sign(sin_mag, sin_neg, s1_exact);
      tw_last  <= s1_last;
    end
  end

endmodule
